// File: rtl/vram_pkg.sv
// Shared widths and owner tags for the video memory arbiter.
package vram_pkg;
  localparam int VRAM_ADDR_WIDTH = 11;
  localparam int VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;
endpackage

// File: rtl/vram_arbiter_tag_pipe.sv
// Owner-tag delay line matching the memory read latency; its last stage
// tells the top which requester the current mem_rdata belongs to.
module arb_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t tag_q [DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= OWN_NONE;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous video memory between the video fetch
// path (fixed priority) and the CPU bus (with a starvation boost).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic                  vid_rvalid,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // A zero-width counter is illegal, so the disabled case keeps one dummy bit.
  localparam int WCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] STARVE_MAX = WCW'(STARVE_LIMIT);

  logic [WCW-1:0]        wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  boost;
  logic                  gnt_vid, gnt_cpu;
  owner_t                tag_in, tag_out;

  assign boost = (STARVE_LIMIT != 0) && (wait_q == STARVE_MAX);

  // Grants are held off while reset is asserted so no access slips through.
  always_comb begin
    gnt_vid = 1'b0;
    gnt_cpu = 1'b0;
    if (!reset) begin
      if (cpu_req && boost)  gnt_cpu = 1'b1;
      else if (vid_req)      gnt_vid = 1'b1;
      else if (cpu_req)      gnt_cpu = 1'b1;
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (gnt_vid)      addr_d = vid_addr;
    else if (gnt_cpu) addr_d = cpu_addr;
  end

  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || gnt_cpu)      wait_d = '0;
    else if (wait_q != STARVE_MAX) wait_d = wait_q + WCW'(1);
  end

  always_comb begin
    tag_in = OWN_NONE;
    if (gnt_vid)                tag_in = OWN_VID;
    else if (gnt_cpu && !cpu_we) tag_in = OWN_CPU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      addr_q <= '0;
    end else begin
      wait_q <= wait_d;
      addr_q <= addr_d;
    end
  end

  arb_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk_i   (clk),
    .reset_i (reset),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  assign vid_ack    = gnt_vid;
  assign cpu_ack    = gnt_cpu;
  assign mem_addr   = addr_d;
  assign mem_we     = gnt_cpu & cpu_we;
  assign mem_wdata  = cpu_wdata;
  assign vid_rvalid = (tag_out == OWN_VID);
  assign cpu_rvalid = (tag_out == OWN_CPU);
  assign vid_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench: three arbiter instances cover default, STARVE_LIMIT=4 and
// strict-priority/READ_LATENCY=3 configurations.
module tb_vram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: defaults, backed by a write-first memory model
  logic        rst_ab, a_vid_req, a_vid_ack, a_vid_rvalid, a_cpu_req, a_cpu_we;
  logic        a_cpu_ack, a_cpu_rvalid, a_mem_we;
  logic [10:0] a_vid_addr, a_cpu_addr, a_mem_addr;
  logic [7:0]  a_vid_rdata, a_cpu_wdata, a_cpu_rdata, a_mem_wdata, a_mem_rdata;
  logic [7:0]  a_mem [0:2047];

  // Instance B: STARVE_LIMIT = 4
  logic        b_vid_req, b_vid_ack, b_vid_rvalid, b_cpu_req, b_cpu_we;
  logic        b_cpu_ack, b_cpu_rvalid, b_mem_we;
  logic [10:0] b_vid_addr, b_cpu_addr, b_mem_addr;
  logic [7:0]  b_vid_rdata, b_cpu_wdata, b_cpu_rdata, b_mem_wdata;
  logic [7:0]  b_mem_rdata = 8'h00;

  // Instance C: STARVE_LIMIT = 0, READ_LATENCY = 3
  logic        rst_c, c_vid_req, c_vid_ack, c_vid_rvalid, c_cpu_req, c_cpu_we;
  logic        c_cpu_ack, c_cpu_rvalid, c_mem_we;
  logic [10:0] c_vid_addr, c_cpu_addr, c_mem_addr;
  logic [7:0]  c_vid_rdata, c_cpu_wdata, c_cpu_rdata, c_mem_wdata;
  logic [7:0]  c_mem_rdata = 8'h00;

  vram_arbiter u_a (
    .clk(clk), .reset(rst_ab),
    .vid_req(a_vid_req), .vid_addr(a_vid_addr), .vid_ack(a_vid_ack),
    .vid_rvalid(a_vid_rvalid), .vid_rdata(a_vid_rdata),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_rvalid(a_cpu_rvalid),
    .cpu_rdata(a_cpu_rdata), .mem_addr(a_mem_addr), .mem_we(a_mem_we),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  vram_arbiter #(.STARVE_LIMIT(4)) u_b (
    .clk(clk), .reset(rst_ab),
    .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_ack(b_vid_ack),
    .vid_rvalid(b_vid_rvalid), .vid_rdata(b_vid_rdata),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack), .cpu_rvalid(b_cpu_rvalid),
    .cpu_rdata(b_cpu_rdata), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  vram_arbiter #(.STARVE_LIMIT(0), .READ_LATENCY(3)) u_c (
    .clk(clk), .reset(rst_c),
    .vid_req(c_vid_req), .vid_addr(c_vid_addr), .vid_ack(c_vid_ack),
    .vid_rvalid(c_vid_rvalid), .vid_rdata(c_vid_rdata),
    .cpu_req(c_cpu_req), .cpu_we(c_cpu_we), .cpu_addr(c_cpu_addr),
    .cpu_wdata(c_cpu_wdata), .cpu_ack(c_cpu_ack), .cpu_rvalid(c_cpu_rvalid),
    .cpu_rdata(c_cpu_rdata), .mem_addr(c_mem_addr), .mem_we(c_mem_we),
    .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
  );

  // Single-port synchronous memory, write-first, one cycle read latency.
  always @(posedge clk) begin
    if (a_mem_we) a_mem[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= a_mem_we ? a_mem_wdata : a_mem[a_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_vid_req = 1'b0; a_cpu_req = 1'b0; a_cpu_we = 1'b0;
    b_vid_req = 1'b0; b_cpu_req = 1'b0; b_cpu_we = 1'b0;
    c_vid_req = 1'b0; c_cpu_req = 1'b0; c_cpu_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) a_mem[i] = 8'(i);
    a_mem_rdata = 8'h00;
    idle_all();
    a_vid_addr = '0; a_cpu_addr = '0; a_cpu_wdata = '0;
    b_vid_addr = '0; b_cpu_addr = '0; b_cpu_wdata = '0;
    c_vid_addr = '0; c_cpu_addr = '0; c_cpu_wdata = '0;
    rst_ab = 1'b1;
    rst_c  = 1'b1;

    // Reset state, with requests asserted to show grants are held off
    a_vid_req = 1'b1; a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 11'h055;
    @(negedge clk);
    check("rst_vid_ack",    32'(a_vid_ack),    32'd0);
    check("rst_cpu_ack",    32'(a_cpu_ack),    32'd0);
    check("rst_vid_rvalid", 32'(a_vid_rvalid), 32'd0);
    check("rst_cpu_rvalid", 32'(a_cpu_rvalid), 32'd0);
    check("rst_mem_we",     32'(a_mem_we),     32'd0);
    check("rst_mem_addr",   32'(a_mem_addr),   32'd0);
    tick();
    idle_all();
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    tick();

    // 1: video streaming reads 0..3, data one cycle after each accept
    for (int k = 0; k < 4; k++) begin
      a_vid_req = 1'b1; a_vid_addr = 11'(k);
      @(negedge clk);
      check("t1_vid_ack",    32'(a_vid_ack),    32'd1);
      check("t1_mem_addr",   32'(a_mem_addr),   32'(k));
      check("t1_vid_rvalid", 32'(a_vid_rvalid), 32'(k > 0));
      if (k > 0) check("t1_vid_rdata", 32'(a_vid_rdata), 32'(k - 1));
      check("t1_cpu_rvalid", 32'(a_cpu_rvalid), 32'd0);
      tick();
    end
    a_vid_req = 1'b0;
    @(negedge clk);
    check("t1_vid_ack_idle",  32'(a_vid_ack),    32'd0);
    check("t1_vid_rvalid_l",  32'(a_vid_rvalid), 32'd1);
    check("t1_vid_rdata_l",   32'(a_vid_rdata),  32'h03);
    check("t1_mem_addr_hold", 32'(a_mem_addr),   32'h003);
    tick();
    @(negedge clk);
    check("t1_vid_rvalid_end", 32'(a_vid_rvalid), 32'd0);
    tick();

    // 2: CPU write 0x123 = A5, read it back
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 11'h123; a_cpu_wdata = 8'hA5;
    @(negedge clk);
    check("t2_wr_ack",   32'(a_cpu_ack),   32'd1);
    check("t2_wr_we",    32'(a_mem_we),    32'd1);
    check("t2_wr_addr",  32'(a_mem_addr),  32'h123);
    check("t2_wr_wdata", 32'(a_mem_wdata), 32'hA5);
    tick();
    a_cpu_we = 1'b0;
    @(negedge clk);
    check("t2_rd_ack",      32'(a_cpu_ack),    32'd1);
    check("t2_rd_we",       32'(a_mem_we),     32'd0);
    check("t2_wr_no_valid", 32'(a_cpu_rvalid), 32'd0);
    tick();
    a_cpu_req = 1'b0;
    @(negedge clk);
    check("t2_cpu_rvalid", 32'(a_cpu_rvalid), 32'd1);
    check("t2_cpu_rdata",  32'(a_cpu_rdata),  32'hA5);
    check("t2_vid_rvalid", 32'(a_vid_rvalid), 32'd0);
    check("t2_mem_we_idle", 32'(a_mem_we),    32'd0);
    tick();
    @(negedge clk);
    check("t2_cpu_rvalid_end", 32'(a_cpu_rvalid), 32'd0);
    tick();

    // 3: STARVE_LIMIT=4, both held: CPU gets every fifth slot
    for (int k = 0; k < 10; k++) begin
      b_vid_req = 1'b1; b_cpu_req = 1'b1; b_cpu_addr = 11'h200; b_vid_addr = 11'h010;
      @(negedge clk);
      check("t3_vid_ack", 32'(b_vid_ack), 32'((k % 5) != 4));
      check("t3_cpu_ack", 32'(b_cpu_ack), 32'((k % 5) == 4));
      if ((k % 5) == 4) check("t3_mem_addr", 32'(b_mem_addr), 32'h200);
      tick();
    end
    idle_all();
    tick();

    // 6: CPU waits 3, drops for one cycle, then needs 4 further waits
    for (int k = 0; k < 9; k++) begin
      b_vid_req = 1'b1; b_cpu_req = (k != 3);
      @(negedge clk);
      check("t6_cpu_ack", 32'(b_cpu_ack), 32'(k == 8));
      check("t6_vid_ack", 32'(b_vid_ack), 32'(k != 8));
      tick();
    end
    idle_all();
    tick();

    // 4: STARVE_LIMIT=0, both held for 100 cycles: CPU never served
    for (int k = 0; k < 100; k++) begin
      c_vid_req = 1'b1; c_cpu_req = 1'b1; c_vid_addr = 11'(k);
      @(negedge clk);
      check("t4_cpu_ack", 32'(c_cpu_ack), 32'd0);
      check("t4_vid_ack", 32'(c_vid_ack), 32'd1);
      tick();
    end
    idle_all();
    for (int k = 0; k < 4; k++) tick();

    // 5: READ_LATENCY=3 read in flight is discarded by reset
    c_cpu_req = 1'b1; c_cpu_we = 1'b0; c_cpu_addr = 11'h010;
    @(negedge clk);
    check("t5_cpu_ack", 32'(c_cpu_ack), 32'd1);
    tick();
    rst_c = 1'b1;
    c_vid_req = 1'b1; c_cpu_req = 1'b1; c_cpu_we = 1'b1;
    @(negedge clk);
    check("t5_rst_vid_ack",    32'(c_vid_ack),    32'd0);
    check("t5_rst_cpu_ack",    32'(c_cpu_ack),    32'd0);
    check("t5_rst_vid_rvalid", 32'(c_vid_rvalid), 32'd0);
    check("t5_rst_cpu_rvalid", 32'(c_cpu_rvalid), 32'd0);
    check("t5_rst_mem_we",     32'(c_mem_we),     32'd0);
    check("t5_rst_mem_addr",   32'(c_mem_addr),   32'd0);
    tick();
    rst_c = 1'b0;
    idle_all();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_no_cpu_rvalid", 32'(c_cpu_rvalid), 32'd0);
      check("t5_no_vid_rvalid", 32'(c_vid_rvalid), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
